// File: rtl/slc3_ctrl_pkg.sv
// Shared types and encodings for the SLC-3 instruction sequencer.
package slc3_ctrl_pkg;

  typedef enum logic [4:0] {
    S_HALTED, S_F1, S_F2, S_F3, S_DEC,
    S_ADD, S_AND, S_NOT, S_BR, S_BR_T, S_JMP, S_JSR, S_JSR2,
    S_L1, S_L2, S_L3, S_S1, S_S2, S_S3, S_P1, S_P2
  } state_t;

  localparam logic [3:0] OP_BR    = 4'b0000;
  localparam logic [3:0] OP_ADD   = 4'b0001;
  localparam logic [3:0] OP_JSR   = 4'b0100;
  localparam logic [3:0] OP_AND   = 4'b0101;
  localparam logic [3:0] OP_LDR   = 4'b0110;
  localparam logic [3:0] OP_STR   = 4'b0111;
  localparam logic [3:0] OP_NOT   = 4'b1001;
  localparam logic [3:0] OP_JMP   = 4'b1100;
  localparam logic [3:0] OP_PAUSE = 4'b1101;

  localparam logic [1:0] PCMUX_PLUS1 = 2'd0;
  localparam logic [1:0] PCMUX_BUS   = 2'd1;
  localparam logic [1:0] PCMUX_ADDER = 2'd2;

  localparam logic [1:0] ADDR2_ZERO  = 2'd0;
  localparam logic [1:0] ADDR2_OFF6  = 2'd1;
  localparam logic [1:0] ADDR2_OFF9  = 2'd2;
  localparam logic [1:0] ADDR2_OFF11 = 2'd3;

  localparam logic [1:0] ALUK_ADD   = 2'd0;
  localparam logic [1:0] ALUK_AND   = 2'd1;
  localparam logic [1:0] ALUK_NOT   = 2'd2;
  localparam logic [1:0] ALUK_PASSA = 2'd3;

  localparam logic DRMUX_IR     = 1'b0;
  localparam logic DRMUX_R7     = 1'b1;
  localparam logic SR1MUX_IR11_9 = 1'b0;
  localparam logic SR1MUX_IR8_6  = 1'b1;
  localparam logic ADDR1_PC     = 1'b0;
  localparam logic ADDR1_BASER  = 1'b1;

  // States that hold a memory strobe and run the shared wait counter.
  function automatic logic is_wait_state(state_t s);
    return (s == S_F2) || (s == S_L2) || (s == S_S3);
  endfunction

endpackage

// File: rtl/slc3_mem_wait_cnt.sv
// Memory-access wait counter: loads a preset, counts down to zero and flags done.
module slc3_mem_wait_cnt (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       load,
  input  logic [2:0] load_val,
  input  logic       dec,
  output logic       done
);

  logic [2:0] cnt;

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      cnt <= 3'd0;
    else if (load)
      cnt <= load_val;
    else if (dec && (cnt != 3'd0))
      cnt <= cnt - 3'd1;
  end

  assign done = (cnt == 3'd0);

endmodule

// File: rtl/slc3_isdu_ctrl.sv
// SLC-3 ISDU: Moore sequencer for fetch/decode/execute of the supported opcodes.
// state     | meaning
// HALTED    | idle until Run;  F1..F3 | fetch;  DEC | dispatch on opcode
// ADD..NOT  | ALU op;  BR/BR_T | branch test / taken;  JMP, JSR/JSR2 | jumps
// L1..L3    | LDR;  S1..S3 | STR;  P1/P2 | pause, two-phase Continue handshake
module slc3_isdu_ctrl
  import slc3_ctrl_pkg::*;
#(
  parameter int unsigned MEM_WAIT = 2
) (
  input  logic       Clk,
  input  logic       Reset_n,
  input  logic       Run,
  input  logic       Continue,
  input  logic [3:0] Opcode,
  input  logic       IR_5,
  input  logic       IR_11,
  input  logic       BEN,
  output logic       LD_MAR,
  output logic       LD_MDR,
  output logic       LD_IR,
  output logic       LD_BEN,
  output logic       LD_CC,
  output logic       LD_REG,
  output logic       LD_PC,
  output logic       LD_LED,
  output logic       GatePC,
  output logic       GateMDR,
  output logic       GateALU,
  output logic       GateMARMUX,
  output logic [1:0] PCMUX,
  output logic       DRMUX,
  output logic       SR1MUX,
  output logic       SR2MUX,
  output logic       ADDR1MUX,
  output logic [1:0] ADDR2MUX,
  output logic [1:0] ALUK,
  output logic       Mem_OE,
  output logic       Mem_WE
);

  localparam logic [2:0] WAIT_PRESET = 3'(MEM_WAIT - 1);

  state_t state, state_nxt;
  logic   cnt_load, cnt_done;

  // F1, L1 and S2 always lead straight into a wait state, so they arm the counter.
  assign cnt_load = (state == S_F1) || (state == S_L1) || (state == S_S2);

  slc3_mem_wait_cnt u_wait (
    .Clk      (Clk),
    .Reset_n  (Reset_n),
    .load     (cnt_load),
    .load_val (WAIT_PRESET),
    .dec      (is_wait_state(state)),
    .done     (cnt_done)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n)
      state <= S_HALTED;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_HALTED: if (Run) state_nxt = S_F1;
      S_F1:     state_nxt = S_F2;
      S_F2:     if (cnt_done) state_nxt = S_F3;
      S_F3:     state_nxt = S_DEC;
      S_DEC: begin
        case (Opcode)
          OP_ADD:   state_nxt = S_ADD;
          OP_AND:   state_nxt = S_AND;
          OP_NOT:   state_nxt = S_NOT;
          OP_BR:    state_nxt = S_BR;
          OP_JMP:   state_nxt = S_JMP;
          OP_JSR:   state_nxt = S_JSR;
          OP_LDR:   state_nxt = S_L1;
          OP_STR:   state_nxt = S_S1;
          OP_PAUSE: state_nxt = S_P1;
          default:  state_nxt = S_F1;
        endcase
      end
      S_BR:     state_nxt = BEN ? S_BR_T : S_F1;
      S_JSR:    state_nxt = S_JSR2;
      S_L1:     state_nxt = S_L2;
      S_L2:     if (cnt_done) state_nxt = S_L3;
      S_S1:     state_nxt = S_S2;
      S_S2:     state_nxt = S_S3;
      S_S3:     if (cnt_done) state_nxt = S_F1;
      S_P1:     if (Continue) state_nxt = S_P2;
      S_P2:     if (!Continue) state_nxt = S_F1;
      S_ADD, S_AND, S_NOT, S_BR_T, S_JMP, S_JSR2, S_L3:
                state_nxt = S_F1;
      default:  state_nxt = S_HALTED;
    endcase
  end

  always_comb begin
    LD_MAR = 1'b0; LD_MDR = 1'b0; LD_IR = 1'b0; LD_BEN = 1'b0;
    LD_CC = 1'b0; LD_REG = 1'b0; LD_PC = 1'b0; LD_LED = 1'b0;
    GatePC = 1'b0; GateMDR = 1'b0; GateALU = 1'b0; GateMARMUX = 1'b0;
    PCMUX = PCMUX_PLUS1; DRMUX = DRMUX_IR; SR1MUX = SR1MUX_IR11_9;
    SR2MUX = 1'b0; ADDR1MUX = ADDR1_PC; ADDR2MUX = ADDR2_ZERO;
    ALUK = ALUK_ADD; Mem_OE = 1'b0; Mem_WE = 1'b0;
    case (state)
      S_F1: begin
        GatePC = 1'b1; LD_MAR = 1'b1; PCMUX = PCMUX_PLUS1; LD_PC = 1'b1;
      end
      S_F2, S_L2: begin
        Mem_OE = 1'b1;
        LD_MDR = cnt_done;
      end
      S_F3: begin
        GateMDR = 1'b1; LD_IR = 1'b1;
      end
      S_DEC: LD_BEN = 1'b1;
      S_ADD, S_AND, S_NOT: begin
        GateALU = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1;
        DRMUX = DRMUX_IR; SR1MUX = SR1MUX_IR8_6;
        SR2MUX = (state == S_NOT) ? 1'b0 : IR_5;
        ALUK = (state == S_ADD) ? ALUK_ADD : (state == S_AND) ? ALUK_AND : ALUK_NOT;
      end
      S_BR_T: begin
        ADDR1MUX = ADDR1_PC; ADDR2MUX = ADDR2_OFF9; PCMUX = PCMUX_ADDER; LD_PC = 1'b1;
      end
      S_JMP: begin
        ADDR1MUX = ADDR1_BASER; ADDR2MUX = ADDR2_ZERO; PCMUX = PCMUX_ADDER; LD_PC = 1'b1;
      end
      S_JSR: begin
        GatePC = 1'b1; DRMUX = DRMUX_R7; LD_REG = 1'b1;
      end
      S_JSR2: begin
        PCMUX = PCMUX_ADDER; LD_PC = 1'b1;
        ADDR1MUX = IR_11 ? ADDR1_PC : ADDR1_BASER;
        ADDR2MUX = IR_11 ? ADDR2_OFF11 : ADDR2_ZERO;
      end
      S_L1, S_S1: begin
        GateMARMUX = 1'b1; LD_MAR = 1'b1; ADDR1MUX = ADDR1_BASER; ADDR2MUX = ADDR2_OFF6;
      end
      S_L3: begin
        GateMDR = 1'b1; LD_REG = 1'b1; LD_CC = 1'b1; DRMUX = DRMUX_IR;
      end
      S_S2: begin
        GateALU = 1'b1; ALUK = ALUK_PASSA; SR1MUX = SR1MUX_IR11_9; LD_MDR = 1'b1;
      end
      S_S3: Mem_WE = 1'b1;
      S_P1: LD_LED = 1'b1;
      default: ;
    endcase
  end

endmodule
